mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache/dcache requesters, the arbiter and the RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;

  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  logic        mem_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: dcache normally has priority, but after
// STARVE_LIMIT back-to-back dcache completions with the icache waiting,
// the icache is granted next. One grant at a time, always via IDLE.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IGRANT = 2'd1,
    ST_DGRANT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_e;

  localparam logic [2:0] LIMIT_C = 3'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        mem_err_q, mem_err_d;

  logic        d_req;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store;
  logic        i_wait, d_wait;

  // Arbitration, RAM steering, completion/abort/error handling and next state.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    mem_err_d = 1'b0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    i_wait    = 1'b1;
    d_wait    = 1'b1;
    d_req     = bus.dREN | bus.dWEN;

    unique case (state_q)
      ST_IDLE: begin
        // A saturated counter only defers the dcache while the icache waits.
        if (d_req && ((starve_q < LIMIT_C) || !bus.iREN)) begin
          state_d = ST_DGRANT;
        end else if (bus.iREN) begin
          state_d = ST_IGRANT;
        end
      end

      ST_IGRANT: begin
        ram_addr  = bus.iaddr;
        mem_err_d = (bus.ramstate == RAM_ERROR);
        if (!bus.iREN) begin
          state_d = ST_IDLE;
        end else begin
          ram_ren = 1'b1;
          if (bus.ramstate == RAM_ACCESS) begin
            i_wait   = 1'b0;
            starve_d = '0;
            state_d  = ST_IDLE;
          end else if (bus.ramstate == RAM_ERROR) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DGRANT: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        mem_err_d = (bus.ramstate == RAM_ERROR);
        if (!d_req) begin
          state_d = ST_IDLE;
        end else begin
          ram_wen = bus.dWEN;
          ram_ren = bus.dREN & ~bus.dWEN;
          if (bus.ramstate == RAM_ACCESS) begin
            d_wait  = 1'b0;
            state_d = ST_IDLE;
            if (!bus.iREN) begin
              starve_d = '0;
            end else if (starve_q < LIMIT_C) begin
              starve_d = starve_q + 3'd1;
            end
          end else if (bus.ramstate == RAM_ERROR) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Grant state, starvation counter and error pulse registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = i_wait;
  assign bus.dwait    = d_wait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.mem_err  = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: the driver computes expected bus values
// from an owner/turn-count model and queues them; a negedge monitor compares.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    logic        iw;
    logic        dw;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the RAM (0 none, 1 icache, 2 dcache),
  // how many dcache turns were taken while the icache waited, pending error.
  int m_owner  = 0;
  int m_turns  = 0;
  bit m_err    = 1'b0;
  bit i_done   = 1'b0;
  bit d_done   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_turns = 0;
    m_err   = 1'b0;
  endtask

  // Apply one cycle of inputs just after the rising edge and queue what the
  // outputs must be during that cycle.
  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] ds,
                       input logic [1:0] rs, input logic [31:0] rl);
    exp_t e;
    bit   granted_req;
    int   next_owner;
    @(posedge clk);
    #1;
    bus.iREN = ir; bus.iaddr = ia; bus.dREN = dr; bus.dWEN = dw;
    bus.daddr = da; bus.dstore = ds; bus.ramstate = rs; bus.ramload = rl;

    e.ren = 1'b0; e.wen = 1'b0; e.addr = '0; e.store = '0; e.load = rl;
    e.iw = 1'b1; e.dw = 1'b1; e.err = m_err;
    i_done = 1'b0; d_done = 1'b0;
    next_owner = 0;

    if (m_owner == 0) begin
      if ((dr || dw) && !(ir && m_turns >= LIMIT)) next_owner = 2;
      else if (ir) next_owner = 1;
      m_err = 1'b0;
    end else begin
      granted_req = (m_owner == 1) ? ir : (dr || dw);
      if (m_owner == 1) e.addr = ia;
      else begin
        e.addr  = da;
        e.store = ds;
      end
      if (granted_req) begin
        if (m_owner == 1) e.ren = 1'b1;
        else begin
          e.wen = dw;
          e.ren = dr && !dw;
        end
        if (rs == ACC) begin
          if (m_owner == 1) begin
            e.iw = 1'b0; i_done = 1'b1; m_turns = 0;
          end else begin
            e.dw = 1'b0; d_done = 1'b1;
            m_turns = ir ? ((m_turns + 1 > LIMIT) ? LIMIT : m_turns + 1) : 0;
          end
        end
      end
      next_owner = (granted_req && (rs == FREE || rs == BUSY)) ? m_owner : 0;
      m_err = (rs == ERR);
    end
    m_owner = next_owner;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, FREE, 32'h0);
  endtask

  // Monitor: compare every queued cycle half a period after the inputs settle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("ramREN",   32'(bus.ramREN),  32'(e.ren));
      chk("ramWEN",   32'(bus.ramWEN),  32'(e.wen));
      chk("ramaddr",  bus.ramaddr,      e.addr);
      chk("ramstore", bus.ramstore,     e.store);
      chk("iwait",    32'(bus.iwait),   32'(e.iw));
      chk("dwait",    32'(bus.dwait),   32'(e.dw));
      chk("iload",    bus.iload,        e.load);
      chk("dload",    bus.dload,        e.load);
      chk("mem_err",  32'(bus.mem_err), 32'(e.err));
    end
  end

  task automatic check_reset_outputs();
    chk("rst_ramREN",   32'(bus.ramREN),  32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN),  32'd0);
    chk("rst_ramaddr",  bus.ramaddr,      32'd0);
    chk("rst_ramstore", bus.ramstore,     32'd0);
    chk("rst_iwait",    32'(bus.iwait),   32'd1);
    chk("rst_dwait",    32'(bus.dwait),   32'd1);
    chk("rst_mem_err",  32'(bus.mem_err), 32'd0);
  endtask

  task automatic clear_inputs();
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;
  endtask

  bit          ir, dr, dw;
  logic [31:0] ia, da, ds;
  logic [1:0]  rs;
  int          pick;

  initial begin
    // Requests present while reset is held must not reach the RAM.
    bus.iREN = 1'b1; bus.iaddr = 32'h11; bus.dREN = 1'b1; bus.dWEN = 1'b1;
    bus.daddr = 32'h22; bus.dstore = 32'h33; bus.ramstate = ACC; bus.ramload = 32'h44;
    #3 check_reset_outputs();
    #8 clear_inputs();
    #1 rst = 1'b0;
    model_reset();

    // Single icache read: two BUSY cycles then ACCESS.
    drive(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, FREE, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, BUSY, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, BUSY, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, ACC,  32'hDEADBEEF);
    idle_cycle();

    // Simultaneous icache read and dcache write: dcache first.
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'h1234, FREE, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h80, 32'h1234, ACC,  32'h0);
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h80, 32'h1234, FREE, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h80, 32'h1234, ACC,  32'h5);
    idle_cycle();

    // Starvation: four dcache turns, then the waiting icache.
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'h44, 1'b1, 1'b0, 32'h88, '0, ACC, 32'(i));
    idle_cycle();

    // dcache abort while RAM is busy.
    drive(1'b0, '0, 1'b1, 1'b0, 32'h90, '0, FREE, 32'h0);
    drive(1'b0, '0, 1'b0, 1'b0, 32'h90, '0, BUSY, 32'h0);
    idle_cycle();

    // RAM error during an icache grant.
    drive(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, FREE, 32'h0);
    drive(1'b1, 32'h50, 1'b0, 1'b0, '0, '0, ERR,  32'h0);
    idle_cycle();
    idle_cycle();

    // Async reset in the middle of a dcache grant with a nonzero turn count.
    drive(1'b1, 32'h60, 1'b1, 1'b0, 32'hA0, '0, FREE, 32'h0);
    drive(1'b1, 32'h60, 1'b1, 1'b0, 32'hA0, '0, ACC,  32'h0);
    drive(1'b1, 32'h60, 1'b1, 1'b0, 32'hA0, '0, FREE, 32'h0);
    drive(1'b1, 32'h60, 1'b1, 1'b0, 32'hA0, '0, BUSY, 32'h0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check_reset_outputs();
    clear_inputs();
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'h64, 1'b1, 1'b0, 32'hA4, '0, ACC, 32'(i + 100));
    idle_cycle();

    // Randomized traffic: requesters mostly hold until done, occasionally abort.
    ir = 1'b0; dr = 1'b0; dw = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!ir) ir = ($urandom_range(99) < 45);
      else if (i_done) ir = ($urandom_range(99) < 40);
      else if ($urandom_range(99) < 4) ir = 1'b0;

      if (!(dr || dw)) begin
        if ($urandom_range(99) < 45) begin
          pick = int'($urandom_range(9));
          dr = (pick < 6) || (pick == 9);
          dw = (pick >= 6);
        end
      end else if (d_done) begin
        if ($urandom_range(99) < 60) begin dr = 1'b0; dw = 1'b0; end
      end else if ($urandom_range(99) < 4) begin
        dr = 1'b0; dw = 1'b0;
      end

      pick = int'($urandom_range(99));
      rs = (pick < 40) ? ACC : (pick < 70) ? BUSY : (pick < 88) ? FREE : ERR;
      ia = $urandom; da = $urandom; ds = $urandom;
      drive(ir, ia, dr, dw, da, ds, rs, $urandom);
    end

    idle_cycle();
    idle_cycle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
